modn_ones_fsm: RTL
==================

Name: modn_ones_fsm

Overview:
- Parametrised Mealy residue-tracking FSM, the generalised successor of the 1-bit even/odd parity detector.
- Each valid beat accepts DATA_W bits. The block counts ones (or zeros) modulo MOD_N and flags combinationally when the residue after the current beat equals TARGET.
- Adds framing (in_last), a synchronous clear, a registered per-frame verdict and a saturating match counter.
- Sits on serial/parallel bit streams feeding link-integrity and pattern-check logic.

Parameters:
- DATA_W, 1: bits consumed per valid beat (>=1).
- MOD_N, 2: modulus of the residue (>=2).
- TARGET, 0: residue value that asserts a match (0 <= TARGET < MOD_N).
- CNT_ONES, 1: 1 = count ones in in_data; 0 = count zeros.
- RESET_RES, 0: residue value at reset, after clr, and at start of each frame (< MOD_N).
- CNT_W, 8: width of match_cnt.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  beat qualifier
- in_data  input  DATA_W  beat data bits
- in_last  input  1  beat is final beat of frame; only meaningful with in_valid
- clr  input  1  synchronous clear, highest synchronous priority
- out_match  output  1  Mealy: (in_valid & ~clr & next_res==TARGET)
- residue  output  RW  current registered residue, RW = max(1,$clog2(MOD_N))
- frame_done  output  1  registered one-cycle pulse after a last beat
- frame_match  output  1  registered verdict of most recent completed frame
- match_cnt  output  CNT_W  count of frames ending in match, saturating

Behaviour:
- Reset (async, reset=1): residue=RESET_RES, frame_done=0, frame_match=0, match_cnt=0. Reset is effective immediately and overrides any beat in flight.
- Beat count k:
  - CNT_ONES=1: k = popcount(in_data).
  - CNT_ONES=0: k = DATA_W - popcount(in_data).
  - Range 0..DATA_W.
- next_res = (residue + k) mod MOD_N, combinational. The intermediate width must hold RESET_RES max + DATA_W without overflow. k may exceed MOD_N; the wrap must be exact for all values, not a single conditional subtract.
- out_match is purely combinational from current inputs and residue (Mealy, zero latency). It is 0 whenever in_valid=0 or clr=1.
- Per clock, priority order:
  1. clr=1: residue<=RESET_RES, frame_done<=0, frame_match<=0, match_cnt<=0. Any same-cycle beat is discarded.
  2. in_valid=1, in_last=0: residue<=next_res; frame_done<=0.
  3. in_valid=1, in_last=1: residue<=RESET_RES (new frame); frame_done<=1; frame_match<=(next_res==TARGET); match_cnt increments if match, holds at 2^CNT_W-1.
  4. in_valid=0: residue holds; frame_done<=0; frame_match and match_cnt hold.
- frame_done is high for exactly one cycle per last beat. Back-to-back last beats give frame_done high on consecutive cycles, and each updates frame_match/match_cnt.
- Single-beat frame (in_last on the first beat) is evaluated from RESET_RES.
- in_last with in_valid=0 is ignored.
- State encoding of residue is binary 0..MOD_N-1. No unreachable value may be entered. If residue were ever >=MOD_N, the mod operation restores a legal value on the next beat.
- Defaults (DATA_W=1, MOD_N=2, TARGET=0, CNT_ONES=1, RESET_RES=0) give the classic even-parity Mealy detector: out_match=1 iff the total ones so far including the current bit is even.
- Out-of-range parameters (MOD_N<2, TARGET>=MOD_N, RESET_RES>=MOD_N, DATA_W<1) are flagged at elaboration via generate-time check/$error.

Test Plan:
- Defaults; after reset drive in_valid=1, in_data=0 -> out_match=1. Then in_data=1 -> out_match=0. Then in_data=1 -> out_match=1. Residue sequence 0,0,1,0.
- DATA_W=8, MOD_N=3, TARGET=0: beats 0xFF (k=8, res 0->2, match 0), 0x01 (res 2->0, match 1), in_last on 0x07 (next 0, match 1) -> frame_done pulse next cycle, frame_match=1, match_cnt=1, residue=0.
- CNT_ONES=0, DATA_W=4, MOD_N=5, TARGET=3: single-beat frame in_data=4'b1000 with in_last -> k=3, out_match=1, frame_match=1, match_cnt increments.
- clr asserted with in_valid=1, in_last=1 mid-frame at residue 1 -> out_match=0, no frame_done, residue=RESET_RES, match_cnt=0 next cycle.
- CNT_W=2: 5 matching single-beat frames back-to-back -> frame_done high 5 consecutive cycles, match_cnt 1,2,3,3,3.
- Async reset pulsed between clock edges mid-frame (residue=1) -> outputs clear immediately without a clock edge. First beat after release evaluates from RESET_RES.

Source files
------------

// File: rtl/modn_ones_fsm.sv
// Mealy residue tracker: counts ones (or zeros) per beat modulo MOD_N, flags a
// combinational match on TARGET, and keeps a per-frame verdict and saturating match count.
module modn_ones_fsm #(
    parameter int DATA_W    = 1,
    parameter int MOD_N     = 2,
    parameter int TARGET    = 0,
    parameter int CNT_ONES  = 1,
    parameter int RESET_RES = 0,
    parameter int CNT_W     = 8,
    localparam int RW       = ($clog2(MOD_N) < 1) ? 1 : $clog2(MOD_N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              clr,
    output logic              out_match,
    output logic [RW-1:0]     residue,
    output logic              frame_done,
    output logic              frame_match,
    output logic [CNT_W-1:0]  match_cnt
);

    localparam int KW = $clog2(DATA_W + 1);
    // Sum width covers the largest encodable residue plus a full beat of ones.
    localparam int SW = RW + KW + 1;
    localparam logic [RW-1:0] RESET_VAL  = RW'(RESET_RES);
    localparam logic [RW-1:0] TARGET_VAL = RW'(TARGET);

    if (DATA_W < 1) begin : g_bad_data_w
        $error("modn_ones_fsm: DATA_W must be >= 1");
    end
    if (MOD_N < 2) begin : g_bad_mod_n
        $error("modn_ones_fsm: MOD_N must be >= 2");
    end
    if ((TARGET < 0) || (TARGET >= MOD_N)) begin : g_bad_target
        $error("modn_ones_fsm: TARGET must be in 0..MOD_N-1");
    end
    if ((RESET_RES < 0) || (RESET_RES >= MOD_N)) begin : g_bad_reset_res
        $error("modn_ones_fsm: RESET_RES must be in 0..MOD_N-1");
    end

    typedef enum logic [1:0] {
        ACT_IDLE = 2'b00,
        ACT_BEAT = 2'b01,
        ACT_LAST = 2'b10,
        ACT_CLR  = 2'b11
    } act_e;

    function automatic logic [KW-1:0] popcount(input logic [DATA_W-1:0] d);
        logic [KW-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            c = c + KW'(d[i]);
        end
        return c;
    endfunction

    logic [RW-1:0]    residue_r;
    logic             frame_done_r;
    logic             frame_match_r;
    logic [CNT_W-1:0] match_cnt_r;

    logic [KW-1:0]    k_s;
    logic [SW-1:0]    sum_s;
    logic [RW-1:0]    next_res_s;
    logic             hit_s;
    act_e             act_s;

    logic [RW-1:0]    residue_d_s;
    logic             frame_done_d_s;
    logic             frame_match_d_s;
    logic [CNT_W-1:0] match_cnt_d_s;

    // Beat weight and exact modular wrap of the running residue.
    always_comb begin
        k_s = '0;
        if (CNT_ONES != 0) begin
            k_s = popcount(in_data);
        end else begin
            k_s = KW'(DATA_W) - popcount(in_data);
        end
        sum_s      = SW'(residue_r) + SW'(k_s);
        next_res_s = RW'(sum_s % SW'(MOD_N));
        hit_s      = (next_res_s == TARGET_VAL);
    end

    // Classify this cycle; clear outranks any beat.
    always_comb begin
        act_s = ACT_IDLE;
        if (clr) begin
            act_s = ACT_CLR;
        end else if (in_valid && in_last) begin
            act_s = ACT_LAST;
        end else if (in_valid) begin
            act_s = ACT_BEAT;
        end else begin
            act_s = ACT_IDLE;
        end
    end

    // Mealy match output, zero latency.
    always_comb begin
        out_match = 1'b0;
        if (in_valid && !clr && hit_s) begin
            out_match = 1'b1;
        end else begin
            out_match = 1'b0;
        end
    end

    // Next-state decode for residue, frame verdict and match counter.
    always_comb begin
        residue_d_s     = residue_r;
        frame_done_d_s  = 1'b0;
        frame_match_d_s = frame_match_r;
        match_cnt_d_s   = match_cnt_r;
        case (act_s)
            ACT_CLR: begin
                residue_d_s     = RESET_VAL;
                frame_match_d_s = 1'b0;
                match_cnt_d_s   = '0;
            end
            ACT_BEAT: begin
                residue_d_s = next_res_s;
            end
            ACT_LAST: begin
                residue_d_s     = RESET_VAL;
                frame_done_d_s  = 1'b1;
                frame_match_d_s = hit_s;
                if (hit_s && (match_cnt_r != {CNT_W{1'b1}})) begin
                    match_cnt_d_s = match_cnt_r + CNT_W'(1);
                end else begin
                    match_cnt_d_s = match_cnt_r;
                end
            end
            ACT_IDLE: begin
                residue_d_s = residue_r;
            end
            default: begin
                residue_d_s = RESET_VAL;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            residue_r     <= RESET_VAL;
            frame_done_r  <= 1'b0;
            frame_match_r <= 1'b0;
            match_cnt_r   <= '0;
        end else begin
            residue_r     <= residue_d_s;
            frame_done_r  <= frame_done_d_s;
            frame_match_r <= frame_match_d_s;
            match_cnt_r   <= match_cnt_d_s;
        end
    end

    assign residue     = residue_r;
    assign frame_done  = frame_done_r;
    assign frame_match = frame_match_r;
    assign match_cnt   = match_cnt_r;

endmodule
